mysystem_onchip_mem_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the single-port 16-bit on-chip memory (180000 words, 18-bit word address, 2 byte lanes) between two Avalon-style masters. Typical masters are a pixel writer and a display reader. The block registers the winning command onto the memory's slave port and routes the one-cycle-latency read data back to the issuing requester. Out-of-range accesses are suppressed and flagged.

---
 rtl/mysystem_mem_arb_pkg.sv | 35 +++
 rtl/mysystem_rr_arb2.sv | 56 +++++
 rtl/mysystem_onchip_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mysystem_onchip_mem_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mysystem_mem_arb_pkg.sv
// ============================================================================
// Module      : mysystem_mem_arb_pkg
// Description : Shared types and default geometry for the on-chip memory
//               arbiter (port ids, response tag, memory dimensions).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mysystem_mem_arb_pkg;

    localparam int MEM_DEPTH = 180000;
    localparam int MEM_AW    = 18;
    localparam int MEM_DW    = 16;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    typedef struct packed {
        logic     valid;
        port_id_e port;
        logic     is_read;
        logic     oor;
    } rsp_tag_t;

    localparam rsp_tag_t TAG_IDLE = '{valid: 1'b0, port: PORT0, is_read: 1'b0, oor: 1'b0};

    function automatic port_id_e other_port(input port_id_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mysystem_rr_arb2.sv
// ============================================================================
// Module      : mysystem_rr_arb2
// Description : Two-way round-robin grant logic; the grant is combinational
//               and the last-winner register biases the next contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mysystem_rr_arb2
    import mysystem_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o,
    output port_id_e   winner_o,
    output logic       any_grant_o
);

    port_id_e last_q;
    port_id_e last_d;

    always_comb begin
        winner_o    = PORT0;
        any_grant_o = 1'b0;
        grant_o     = 2'b00;
        last_d      = last_q;

        // Grants are held off while reset is asserted, even with requests up.
        if (reset_n) begin
            case (req_i)
                2'b01:   winner_o = PORT0;
                2'b10:   winner_o = PORT1;
                2'b11:   winner_o = other_port(last_q);
                default: winner_o = PORT0;
            endcase
            any_grant_o = |req_i;
        end

        if (any_grant_o) begin
            grant_o = (winner_o == PORT1) ? 2'b10 : 2'b01;
            last_d  = winner_o;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mysystem_onchip_mem_arbiter.sv
// ============================================================================
// Module      : mysystem_onchip_mem_arbiter
// Description : Round-robin sharing of a single-port on-chip memory between
//               two masters, with range checking and read-data routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mysystem_onchip_mem_arbiter
    import mysystem_mem_arb_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    parameter int BEW   = MEM_DW / 8
) (
    input  logic           clk,
    input  logic           reset_n,

    input  logic           p0_req,
    input  logic           p0_write,
    input  logic [AW-1:0]  p0_address,
    input  logic [BEW-1:0] p0_byteenable,
    input  logic [DW-1:0]  p0_writedata,
    output logic           p0_grant,
    output logic           p0_readdatavalid,
    output logic [DW-1:0]  p0_readdata,
    output logic           p0_err,

    input  logic           p1_req,
    input  logic           p1_write,
    input  logic [AW-1:0]  p1_address,
    input  logic [BEW-1:0] p1_byteenable,
    input  logic [DW-1:0]  p1_writedata,
    output logic           p1_grant,
    output logic           p1_readdatavalid,
    output logic [DW-1:0]  p1_readdata,
    output logic           p1_err,

    output logic [AW-1:0]  mem_address,
    output logic [BEW-1:0] mem_byteenable,
    output logic           mem_chipselect,
    output logic           mem_write,
    output logic [DW-1:0]  mem_writedata,
    output logic           mem_clken,
    input  logic [DW-1:0]  mem_readdata
);

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [1:0]     w_req;
    logic [1:0]     w_grant;
    port_id_e       w_winner;
    logic           w_any;

    logic           w_sel_write;
    logic [AW-1:0]  w_sel_addr;
    logic [BEW-1:0] w_sel_be;
    logic [DW-1:0]  w_sel_wdata;
    logic           w_oor;

    logic           cs_q,    cs_d;
    logic           wr_q,    wr_d;
    logic [AW-1:0]  addr_q,  addr_d;
    logic [BEW-1:0] be_q,    be_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           clken_q;

    rsp_tag_t       tag1_q, tag1_d;
    rsp_tag_t       tag2_q;

    assign w_req = {p1_req, p0_req};

    mysystem_rr_arb2 u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (w_req),
        .grant_o     (w_grant),
        .winner_o    (w_winner),
        .any_grant_o (w_any)
    );

    assign p0_grant = w_grant[0];
    assign p1_grant = w_grant[1];

    always_comb begin
        if (w_winner == PORT1) begin
            w_sel_write = p1_write;
            w_sel_addr  = p1_address;
            w_sel_be    = p1_byteenable;
            w_sel_wdata = p1_writedata;
        end else begin
            w_sel_write = p0_write;
            w_sel_addr  = p0_address;
            w_sel_be    = p0_byteenable;
            w_sel_wdata = p0_writedata;
        end
    end

    assign w_oor = ({1'b0, w_sel_addr} >= C_DEPTH);

    // Address/data hold their last value on idle cycles to avoid needless toggling.
    always_comb begin
        cs_d    = w_any & ~w_oor;
        wr_d    = w_any & ~w_oor & w_sel_write;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        tag1_d  = TAG_IDLE;
        if (w_any) begin
            addr_d  = w_sel_addr;
            be_d    = w_sel_be;
            wdata_d = w_sel_wdata;
            tag1_d  = '{valid: 1'b1, port: w_winner, is_read: ~w_sel_write, oor: w_oor};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            clken_q <= 1'b0;
            tag1_q  <= TAG_IDLE;
            tag2_q  <= TAG_IDLE;
        end else begin
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            clken_q <= 1'b1;
            tag1_q  <= tag1_d;
            tag2_q  <= tag1_q;
        end
    end

    assign mem_chipselect = cs_q;
    assign mem_write      = wr_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = clken_q;

    // Stage 2 lines up with the memory's registered read data.
    always_comb begin
        p0_readdatavalid = 1'b0;
        p0_readdata      = '0;
        p0_err           = 1'b0;
        p1_readdatavalid = 1'b0;
        p1_readdata      = '0;
        p1_err           = 1'b0;
        if (tag2_q.valid) begin
            if (tag2_q.port == PORT0) begin
                p0_readdatavalid = tag2_q.is_read;
                p0_err           = tag2_q.oor;
                if (tag2_q.is_read && !tag2_q.oor) begin
                    p0_readdata = mem_readdata;
                end
            end else begin
                p1_readdatavalid = tag2_q.is_read;
                p1_err           = tag2_q.oor;
                if (tag2_q.is_read && !tag2_q.oor) begin
                    p1_readdata = mem_readdata;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mysystem_onchip_mem_arbiter.sv
// ============================================================================
// Module      : tb_mysystem_onchip_mem_arbiter
// Description : Scoreboard bench for the on-chip memory arbiter with a
//               behavioural memory and a grant-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mysystem_onchip_mem_arbiter;

    localparam int DEPTH = 180000;
    localparam int AW    = 18;
    localparam int DW    = 16;
    localparam int BEW   = 2;

    typedef struct {
        logic           write;
        logic [AW-1:0]  addr;
        logic [BEW-1:0] be;
        logic [DW-1:0]  wdata;
    } cmd_t;

    typedef struct {
        int            cyc;
        int            port;
        logic          rdv;
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    typedef struct {
        int             cyc;
        logic           cs;
        logic           wr;
        logic [AW-1:0]  addr;
        logic [BEW-1:0] be;
        logic [DW-1:0]  wdata;
    } mcmd_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           p0_req = 1'b0, p0_write = 1'b0;
    logic [AW-1:0]  p0_address = '0;
    logic [BEW-1:0] p0_byteenable = '0;
    logic [DW-1:0]  p0_writedata = '0;
    logic           p1_req = 1'b0, p1_write = 1'b0;
    logic [AW-1:0]  p1_address = '0;
    logic [BEW-1:0] p1_byteenable = '0;
    logic [DW-1:0]  p1_writedata = '0;
    logic           p0_grant, p0_readdatavalid, p0_err;
    logic           p1_grant, p1_readdatavalid, p1_err;
    logic [DW-1:0]  p0_readdata, p1_readdata;
    logic [AW-1:0]  mem_address;
    logic [BEW-1:0] mem_byteenable;
    logic           mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0]  mem_writedata;
    logic [DW-1:0]  mem_readdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    cmd_t  q0[$];
    cmd_t  q1[$];
    rsp_t  rq[$];
    mcmd_t mq[$];
    int    gnt_log[$];
    int    model_last = 1;

    logic [DW-1:0] phys    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    mysystem_onchip_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .p0_req           (p0_req),
        .p0_write         (p0_write),
        .p0_address       (p0_address),
        .p0_byteenable    (p0_byteenable),
        .p0_writedata     (p0_writedata),
        .p0_grant         (p0_grant),
        .p0_readdatavalid (p0_readdatavalid),
        .p0_readdata      (p0_readdata),
        .p0_err           (p0_err),
        .p1_req           (p1_req),
        .p1_write         (p1_write),
        .p1_address       (p1_address),
        .p1_byteenable    (p1_byteenable),
        .p1_writedata     (p1_writedata),
        .p1_grant         (p1_grant),
        .p1_readdatavalid (p1_readdatavalid),
        .p1_readdata      (p1_readdata),
        .p1_err           (p1_err),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Single-port synchronous memory, one-cycle read latency, junk when idle.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (int'(mem_address) >= DEPTH) begin
                check("mem_access_range", 64'(mem_address), 64'(DEPTH - 1));
            end else begin
                if (mem_write) begin
                    for (int b = 0; b < BEW; b++) begin
                        if (mem_byteenable[b]) phys[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                    end
                end
                mem_readdata <= phys[mem_address];
            end
        end else begin
            mem_readdata <= 16'($urandom) | 16'h8001;
        end
    end

    function automatic cmd_t mk_cmd(input logic wr, input int addr, input logic [BEW-1:0] be,
                                    input logic [DW-1:0] wd);
        cmd_t c;
        c.write = wr;
        c.addr  = AW'(addr);
        c.be    = be;
        c.wdata = wd;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        int sel;
        int a;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0, 1, 2, 3, 4, 5: a = int'($urandom_range(0, 31));
            6, 7:             a = int'($urandom_range(DEPTH - 2, DEPTH + 1));
            8:                a = int'($urandom_range(DEPTH, (1 << AW) - 1));
            default:          a = int'($urandom_range(0, DEPTH - 1));
        endcase
        return mk_cmd($urandom_range(0, 1) == 1, a, BEW'($urandom_range(0, 3)), DW'($urandom));
    endfunction

    // Reference behaviour: accesses take effect in grant order.
    task automatic issue(input int port, input cmd_t c);
        rsp_t  r;
        mcmd_t m;
        bit    oor;
        oor     = int'(c.addr) >= DEPTH;
        m.cyc   = cyc + 1;
        m.cs    = !oor;
        m.wr    = !oor && c.write;
        m.addr  = c.addr;
        m.be    = c.be;
        m.wdata = c.wdata;
        mq.push_back(m);
        r.cyc  = cyc + 2;
        r.port = port;
        r.err  = oor;
        r.rdv  = !c.write;
        r.data = '0;
        if (!c.write && !oor) r.data = ref_mem[c.addr];
        if (c.write && !oor) begin
            for (int b = 0; b < BEW; b++) begin
                if (c.be[b]) ref_mem[c.addr][8*b +: 8] = c.wdata[8*b +: 8];
            end
        end
        if (!c.write || oor) rq.push_back(r);
    endtask

    // Request driver: presents the head of each port's command queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                p0_req = 1'b1; p0_write = q0[0].write; p0_address = q0[0].addr;
                p0_byteenable = q0[0].be; p0_writedata = q0[0].wdata;
            end else begin
                p0_req = 1'b0;
            end
            if (q1.size() > 0) begin
                p1_req = 1'b1; p1_write = q1[0].write; p1_address = q1[0].addr;
                p1_byteenable = q1[0].be; p1_writedata = q1[0].wdata;
            end else begin
                p1_req = 1'b0;
            end
        end
    end

    // Arbitration model and scoreboard producer.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                model_last = 1;
            end else begin : arb_blk
                int   eg;
                cmd_t c;
                eg = -1;
                if (p0_req && p1_req) eg = 1 - model_last;
                else if (p0_req)      eg = 0;
                else if (p1_req)      eg = 1;
                if (p0_req || p1_req || p0_grant || p1_grant)
                    check("grant", 64'({p1_grant, p0_grant}), (eg < 0) ? 64'd0 : (64'd1 << eg));
                if (eg >= 0) begin
                    model_last = eg;
                    gnt_log.push_back(eg);
                    if (eg == 0) c = q0.pop_front();
                    else         c = q1.pop_front();
                    issue(eg, c);
                end
            end
        end
    end

    // Monitor: compares memory commands and responses as the DUT presents them.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin : mon_blk
                bit            due, seen;
                logic [1:0]    e_rdv, e_err;
                logic [DW-1:0] e_d0, e_d1;
                rsp_t          r;
                mcmd_t         m;
                if (mq.size() > 0 && mq[0].cyc == cyc) begin
                    m = mq.pop_front();
                    check("mem_cs_wr", 64'({mem_chipselect, mem_write}), 64'({m.cs, m.wr}));
                    if (m.cs) check("mem_address", 64'(mem_address), 64'(m.addr));
                    if (m.wr) check("mem_be_wdata", 64'({mem_byteenable, mem_writedata}),
                                    64'({m.be, m.wdata}));
                end else if (mem_chipselect) begin
                    check("mem_cs_unexpected", 64'(mem_chipselect), 64'd0);
                end
                due  = rq.size() > 0 && rq[0].cyc == cyc;
                seen = p0_readdatavalid | p0_err | p1_readdatavalid | p1_err |
                       (|p0_readdata) | (|p1_readdata);
                if (due || seen) begin
                    e_rdv = '0; e_err = '0; e_d0 = '0; e_d1 = '0;
                    if (due) begin
                        r = rq.pop_front();
                        e_rdv[r.port] = r.rdv;
                        e_err[r.port] = r.err;
                        if (r.port == 0) e_d0 = r.data;
                        else             e_d1 = r.data;
                    end
                    check("response", 64'({p1_readdatavalid, p1_err, p1_readdata,
                                           p0_readdatavalid, p0_err, p0_readdata}),
                                      64'({e_rdv[1], e_err[1], e_d1, e_rdv[0], e_err[0], e_d0}));
                end
                if (rq.size() > 0 && rq[0].cyc < cyc) begin
                    r = rq.pop_front();
                    check("response_missing", 64'd0, 64'd1);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_ports"}, 64'({p0_grant, p1_grant, p0_readdatavalid, p1_readdatavalid,
                                     p0_err, p1_err, p0_readdata, p1_readdata}), 64'd0);
        check({name, "_mem"}, 64'({mem_chipselect, mem_write, mem_address, mem_byteenable,
                                   mem_writedata, mem_clken}), 64'd0);
    endtask

    task automatic wait_rdv(input int port, input string name, output logic [DW-1:0] data,
                            output logic err);
        bit found;
        found = 1'b0;
        data  = '0;
        err   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (port == 0 && (p0_readdatavalid || p0_err)) begin
                found = 1'b1; data = p0_readdata; err = p0_err;
            end else if (port == 1 && (p1_readdatavalid || p1_err)) begin
                found = 1'b1; data = p1_readdata; err = p1_err;
            end
        end
        check({name, "_seen"}, 64'(found), 64'd1);
    endtask

    task automatic drain(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            idle = (q0.size() == 0) && (q1.size() == 0) && (rq.size() == 0) && (mq.size() == 0);
        end
        check({name, "_drained"}, 64'(idle), 64'd1);
    endtask

    task automatic next_slot();
        @(posedge clk);
        #2;
    endtask

    initial begin : main
        logic [DW-1:0] d;
        logic          e;
        int            lo1;
        for (int i = 0; i < DEPTH; i++) begin
            phys[i]    = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        phys[16'h10] = 16'hBEEF; ref_mem[16'h10] = 16'hBEEF;
        phys[16'h20] = 16'h1234; ref_mem[16'h20] = 16'h1234;

        // Requests are up during reset; nothing may be granted.
        q0.push_back(mk_cmd(1'b0, 5, 2'b11, 16'h0));
        q1.push_back(mk_cmd(1'b1, 6, 2'b11, 16'h1111));
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        q0.delete(); q1.delete();
        next_slot();
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("clken_after_reset", 64'(mem_clken), 64'd1);

        next_slot();
        q0.push_back(mk_cmd(1'b0, 'h10, 2'b11, 16'h0));
        wait_rdv(0, "single_read", d, e);
        check("single_read_data", 64'(d), 64'hBEEF);
        drain("single_read");

        next_slot();
        q1.push_back(mk_cmd(1'b0, 'h10, 2'b11, 16'h0));
        drain("p1_read");

        gnt_log.delete();
        next_slot();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk_cmd(1'b0, 2 * i, 2'b11, 16'h0));
            q1.push_back(mk_cmd(1'b0, 2 * i + 1, 2'b11, 16'h0));
        end
        drain("contention");
        check("contention_count", 64'(gnt_log.size()), 64'd6);
        for (int i = 0; i < gnt_log.size() && i < 6; i++)
            check("contention_order", 64'(gnt_log[i]), 64'(i % 2));

        next_slot();
        q1.push_back(mk_cmd(1'b1, 'h20, 2'b01, 16'hA55A));
        next_slot();
        q0.push_back(mk_cmd(1'b0, 'h20, 2'b11, 16'h0));
        wait_rdv(0, "byte_raw", d, e);
        check("byte_raw_data", 64'(d), 64'h125A);
        drain("byte_raw");

        next_slot();
        q0.push_back(mk_cmd(1'b0, DEPTH - 1, 2'b11, 16'h0));
        wait_rdv(0, "last_word", d, e);
        check("last_word_data_err", 64'({e, d}), 64'({1'b0, 16'hE545}));
        next_slot();
        q0.push_back(mk_cmd(1'b1, DEPTH, 2'b11, 16'hFFFF));
        wait_rdv(0, "oor_write", d, e);
        check("oor_write_err", 64'(e), 64'd1);
        drain("boundary");

        for (int i = 0; i < 400; i++) begin
            next_slot();
            if (q0.size() < 2 && $urandom_range(0, 3) != 0) q0.push_back(rand_cmd());
            if (q1.size() < 2 && $urandom_range(0, 3) != 0) q1.push_back(rand_cmd());
        end
        drain("random");

        next_slot();
        q1.push_back(mk_cmd(1'b0, 'h30, 2'b11, 16'h0));
        for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge clk);
        check("midflight_granted", 64'(q1.size()), 64'd0);
        next_slot();
        reset_n = 1'b0;
        rq.delete(); mq.delete();
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset_midflight");
        end
        next_slot();
        reset_n = 1'b1;
        lo1 = 0;
        repeat (4) begin
            @(negedge clk);
            if (p1_readdatavalid) lo1++;
        end
        check("no_stale_rdv", 64'(lo1), 64'd0);
        gnt_log.delete();
        next_slot();
        q0.push_back(mk_cmd(1'b0, 1, 2'b11, 16'h0));
        q1.push_back(mk_cmd(1'b0, 2, 2'b11, 16'h0));
        drain("post_reset");
        check("post_reset_first_grant", (gnt_log.size() > 0) ? 64'(gnt_log[0]) : 64'd9, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
